// File: rtl/maze_pkg.sv
// Shared types and constants for the maze controller datapath.
// The UART transmitter takes its state encoding and default divider from here.
package maze_pkg;

  typedef enum logic {
    IDLE         = 1'b0,
    TRANSMITTING = 1'b1
  } uart_tx_state_t;

  // 50 MHz system clock / 19200 baud
  localparam int unsigned UART_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per trmt strobe, LSB first, tx_done on the
// final cycle of the stop bit.
module uart_tx
  import maze_pkg::*;
#(
  parameter int unsigned BAUD_DIV = UART_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_TC = CW'(BAUD_DIV - 1);

  uart_tx_state_t state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [3:0]     bit_q, bit_d;
  logic [9:0]     shift_q, shift_d;

  logic load, baud_tc, last;

  // tx_done is decoded from registers during the last stop-bit cycle, while the
  // FSM is still TRANSMITTING; that is why a trmt in that cycle is not taken.
  always_comb begin
    load    = (state_q == IDLE) && trmt;
    baud_tc = (state_q == TRANSMITTING) && (baud_q == BAUD_TC);
    last    = baud_tc && (bit_q == 4'd9);

    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = TRANSMITTING;
          baud_d  = '0;
          bit_d   = '0;
          shift_d = {1'b1, tx_data, 1'b0};
        end
      end
      TRANSMITTING: begin
        baud_d = baud_tc ? '0 : baud_q + 1'b1;
        if (baud_tc) begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[9:1]};
        end
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) baud_q <= '0;
    else        baud_q <= baud_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_q <= '0;
    else        bit_q <= bit_d;
  end

  // All-ones reset keeps the line idle-high the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shift_q <= '1;
    else        shift_q <= shift_d;
  end

  assign TX      = shift_q[0];
  assign tx_done = last;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_DIV=8: bit timing, done pulse placement,
// ignored strobes, back-to-back and repeating frames, async reset mid-frame.
module tb_uart_tx;

  localparam int BD = 8;

  logic       clk;
  logic       rst_n;
  logic       trmt;
  logic [7:0] tx_data;
  logic       TX;
  logic       tx_done;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int done_t[$];

  uart_tx #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_done === 1'b1) done_t.push_back(cyc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk({tag, "_tx"},   32'(TX),      32'(1'b1));
      chk({tag, "_done"}, 32'(tx_done), 32'(1'b0));
    end
  endtask

  // Strobe trmt for one cycle; k is the cycle index of the accepting edge.
  task automatic send(input logic [7:0] d, output int k);
    @(negedge clk);
    tx_data = d;
    trmt    = 1'b1;
    @(posedge clk);
    #1 trmt = 1'b0;
    k = cyc;
  endtask

  // Called just after the accepting edge; checks all 80 cycles of the frame.
  // inj >= 0 re-asserts trmt with 0x3C for one cycle at that point.
  task automatic frame_check(input logic [7:0] d, input int inj);
    logic e;
    for (int j = 0; j < 10 * BD; j++) begin
      @(negedge clk);
      if (j < BD)            e = 1'b0;
      else if (j < 9 * BD)   e = d[j / BD - 1];
      else                   e = 1'b1;
      chk("tx_bit",  32'(TX),      32'(e));
      chk("tx_done", 32'(tx_done), 32'(j == 10 * BD - 1));
      if (inj >= 0 && j == inj) begin
        trmt = 1'b1; tx_data = 8'h3C;
      end else if (inj >= 0 && j == inj + 1) begin
        trmt = 1'b0;
      end
    end
  endtask

  initial begin
    int k, k2;
    rst_n = 1'b0; trmt = 1'b0; tx_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",   32'(TX),      32'(1'b1));
    chk("rst_done", 32'(tx_done), 32'(1'b0));
    rst_n = 1'b1;
    idle_check(100, "idle");

    // Single 0xA5 frame
    done_t.delete();
    send(8'hA5, k);
    frame_check(8'hA5, -1);
    idle_check(5, "post_a5");
    chk("a5_done_cnt", 32'(done_t.size()), 32'd1);
    if (done_t.size() > 0) chk("a5_done_at", 32'(done_t[0] + 1 - k), 32'd80);

    // All-zero then all-one data
    send(8'h00, k);
    frame_check(8'h00, -1);
    idle_check(3, "post_00");
    send(8'hFF, k);
    frame_check(8'hFF, -1);
    idle_check(3, "post_ff");

    // Strobe and new data mid-frame are ignored
    done_t.delete();
    send(8'hA5, k);
    frame_check(8'hA5, 30);
    idle_check(100, "no_2nd");
    chk("inj_done_cnt", 32'(done_t.size()), 32'd1);

    // Back-to-back: trmt raised the cycle after tx_done
    done_t.delete();
    send(8'h12, k);
    frame_check(8'h12, -1);
    @(posedge clk);
    #1 trmt = 1'b1; tx_data = 8'h34;
    @(negedge clk);
    chk("b2b_gap_tx",   32'(TX),      32'(1'b1));
    chk("b2b_gap_done", 32'(tx_done), 32'(1'b0));
    @(posedge clk);
    #1 trmt = 1'b0;
    k2 = cyc;
    chk("b2b_accept", 32'(k2 - k), 32'd81);
    frame_check(8'h34, -1);
    idle_check(3, "post_b2b");
    chk("b2b_done_cnt", 32'(done_t.size()), 32'd2);
    if (done_t.size() == 2) chk("b2b_done_sp", 32'(done_t[1] - done_t[0]), 32'd81);

    // trmt held high: a frame every 81 cycles
    done_t.delete();
    @(negedge clk);
    tx_data = 8'h5A; trmt = 1'b1;
    @(posedge clk);
    #1 k = cyc;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) trmt = 1'b0;
      frame_check(8'h5A, -1);
      if (f < 2) begin
        @(negedge clk);
        chk("rep_gap_tx",   32'(TX),      32'(1'b1));
        chk("rep_gap_done", 32'(tx_done), 32'(1'b0));
        @(posedge clk);
        #1 chk("rep_period", 32'(cyc - k), 32'(81 * (f + 1)));
      end
    end
    idle_check(20, "post_rep");
    chk("rep_done_cnt", 32'(done_t.size()), 32'd3);
    if (done_t.size() == 3) begin
      chk("rep_sp0", 32'(done_t[1] - done_t[0]), 32'd81);
      chk("rep_sp1", 32'(done_t[2] - done_t[1]), 32'd81);
    end

    // Async reset mid-frame: line high at once, frame abandoned
    done_t.delete();
    send(8'hA5, k);
    repeat (20) @(negedge clk);
    chk("mid_tx_before", 32'(TX), 32'(1'b0));
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_tx", 32'(TX), 32'(1'b1));
    chk("mid_rst_done", 32'(tx_done), 32'(1'b0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_check(100, "post_rst");
    chk("rst_no_done", 32'(done_t.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
